mc_request_queue: RTL

//  Memory-controller front end that terminates the cache-side transaction handshake (valid_tran/ack_tran).
//  - Accepts one request per handshake.
//  - Allocates a 3-bit transaction tag and returns it on tag_tran.
//  - Queues {rw,addr,data,tag} in order for the DDR4 command scheduler.
//  - Raises full when it cannot accept another request.

---
 rtl/mc_req_pkg.sv | 35 +++
 rtl/mc_request_queue_if.sv | 38 +++
 rtl/mc_tag_alloc.sv | 48 ++++
 rtl/mc_request_queue.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mc_req_pkg.sv
// Shared types and constants for the memory-controller request queue.
// Holds the tag geometry, the handshake FSM state encoding, the queued
// request record and a lowest-free-tag priority picker.
package mc_req_pkg;

    localparam int TAG_W      = 3;
    localparam int NTAGS      = 8;
    localparam int REQ_AWIDTH = 32;
    localparam int REQ_DWIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        DROP = 2'd2
    } rq_state_t;

    typedef struct packed {
        logic                  rw;
        logic [REQ_AWIDTH-1:0] addr;
        logic [REQ_DWIDTH-1:0] data;
        logic [TAG_W-1:0]      tag;
    } req_t;

    // Returns the index of the lowest set bit; 0 when the mask is empty,
    // so callers must qualify the result with an any-free flag.
    function automatic logic [TAG_W-1:0] lowestFree(input logic [NTAGS-1:0] mask);
        lowestFree = '0;
        for (int i = NTAGS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowestFree = TAG_W'(i);
            end
        end
    endfunction

endpackage

// File: rtl/mc_request_queue_if.sv
// Bus bundle for the request queue: cache-side transaction handshake,
// scheduler-side command stream and the tag-retire path from responses.
// The slave modport is the queue's view, master is the surroundings.
interface mc_request_queue_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 64
);
    import mc_req_pkg::*;

    logic              valid_tran;
    logic              rw;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data_tran;
    logic              ack_tran;
    logic [TAG_W-1:0]  tag_tran;
    logic              full;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_rw;
    logic [AWIDTH-1:0] cmd_addr;
    logic [DWIDTH-1:0] cmd_data;
    logic [TAG_W-1:0]  cmd_tag;

    logic              rel_valid;
    logic [TAG_W-1:0]  rel_tag;

    modport slave (
        input  valid_tran, rw, addr, data_tran, cmd_ready, rel_valid, rel_tag,
        output ack_tran, tag_tran, full, cmd_valid, cmd_rw, cmd_addr, cmd_data, cmd_tag
    );

    modport master (
        output valid_tran, rw, addr, data_tran, cmd_ready, rel_valid, rel_tag,
        input  ack_tran, tag_tran, full, cmd_valid, cmd_rw, cmd_addr, cmd_data, cmd_tag
    );

endinterface

// File: rtl/mc_tag_alloc.sv
// Transaction tag allocator: a free mask of NTAGS bits with a lowest-free
// pick. Allocation always picks from the current (pre-release) mask, so a
// tag retired this cycle cannot be handed out again until the next cycle.
// any_free_o reports whether any tag remains free after this edge's update.
module mc_tag_alloc
    import mc_req_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc_i,
    input  logic             rel_valid_i,
    input  logic [TAG_W-1:0] rel_tag_i,
    output logic [TAG_W-1:0] pick_tag_o,
    output logic             any_free_o
);

    logic [NTAGS-1:0] freeMask_q;
    logic [NTAGS-1:0] freeMask_d;
    logic [NTAGS-1:0] allocMask;
    logic [NTAGS-1:0] relMask;

    assign pick_tag_o = lowestFree(freeMask_q);
    assign any_free_o = |freeMask_d;

    // Next free mask: clear the picked tag, set the retired tag only if it was busy.
    always_comb begin
        allocMask = '0;
        relMask   = '0;
        if (alloc_i) begin
            allocMask[pick_tag_o] = 1'b1;
        end
        if (rel_valid_i) begin
            relMask[rel_tag_i] = 1'b1;
        end
        relMask    = relMask & ~freeMask_q;
        freeMask_d = (freeMask_q & ~allocMask) | relMask;
    end

    // Free mask register; every tag is free out of reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            freeMask_q <= '1;
        end else begin
            freeMask_q <= freeMask_d;
        end
    end

endmodule

// File: rtl/mc_request_queue.sv
// Memory-controller request queue front end. Terminates the cache-side
// valid_tran/ack_tran handshake, tags each accepted request, and queues
// {rw,addr,data,tag} in order for the DDR4 command scheduler.
// Optional feature macro: REQ_QUEUE_STATS_EN adds saturating stat_rd,
// stat_wr and stat_full counters; without it those ports do not exist.
module mc_request_queue
    import mc_req_pkg::*;
#(
    parameter int AWIDTH = REQ_AWIDTH,
    parameter int DWIDTH = REQ_DWIDTH,
    parameter int DEPTH  = 8
) (
    input  logic                clock,
    input  logic                reset,
    mc_request_queue_if.slave   bus
`ifdef REQ_QUEUE_STATS_EN
    ,
    output logic [15:0]         stat_rd,
    output logic [15:0]         stat_wr,
    output logic [15:0]         stat_full
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    rq_state_t         state_q, state_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    req_t              queue_q [DEPTH];

    logic              accept;
    logic              pop;
    logic              cmdValid;
    logic [TAG_W-1:0]  pickTag;
    logic              anyFree;
    logic [AWIDTH-1:0] reqAddr;
    logic [DWIDTH-1:0] reqData;
    req_t              newEntry;
    req_t              head;

    assign accept   = (state_q == IDLE) && bus.valid_tran && !full_q;
    assign cmdValid = (count_q != '0);
    assign pop      = cmdValid && bus.cmd_ready;
    assign reqAddr  = bus.addr;
    assign reqData  = bus.data_tran;
    assign newEntry = '{rw: bus.rw, addr: reqAddr, data: reqData, tag: pickTag};
    assign head     = queue_q[rdPtr_q];

    mc_tag_alloc u_tag_alloc (
        .clock       (clock),
        .reset       (reset),
        .alloc_i     (accept),
        .rel_valid_i (bus.rel_valid),
        .rel_tag_i   (bus.rel_tag),
        .pick_tag_o  (pickTag),
        .any_free_o  (anyFree)
    );

    // Handshake state register plus the tag echoed back during ACK.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
        end
    end

    // Handshake next state: accept once, pulse ACK, then wait for valid to drop.
    always_comb begin
        state_d = state_q;
        tag_d   = accept ? pickTag : tag_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACK;
            ACK:     state_d = DROP;
            DROP:    if (!bus.valid_tran) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: ack pulse from the state, command head gated so it reads 0 when empty.
    always_comb begin
        bus.ack_tran  = (state_q == ACK);
        bus.tag_tran  = (state_q == ACK) ? tag_q : '0;
        bus.full      = full_q;
        bus.cmd_valid = cmdValid;
        bus.cmd_rw    = cmdValid ? head.rw   : 1'b0;
        bus.cmd_addr  = cmdValid ? head.addr : '0;
        bus.cmd_data  = cmdValid ? head.data : '0;
        bus.cmd_tag   = cmdValid ? head.tag  : '0;
    end

    // Queue bookkeeping: pointers wrap modulo DEPTH, full looks at post-edge occupancy and tags.
    always_comb begin
        wrPtr_d = wrPtr_q + PTR_W'(accept);
        rdPtr_d = rdPtr_q + PTR_W'(pop);
        count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
        full_d  = (count_d == CNT_W'(DEPTH)) || !anyFree;
    end

    // Pointer, occupancy and full registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    // Queue storage needs no reset; the head is only exposed while occupancy is nonzero.
    always_ff @(posedge clock) begin
        if (accept) begin
            queue_q[wrPtr_q] <= newEntry;
        end
    end

`ifdef REQ_QUEUE_STATS_EN
    logic [15:0] statRd_q, statWr_q, statFull_q;

    assign stat_rd   = statRd_q;
    assign stat_wr   = statWr_q;
    assign stat_full = statFull_q;

    // Saturating counters for accepted reads, accepted writes and cycles spent full.
    always_ff @(posedge clock) begin
        if (!reset) begin
            statRd_q   <= '0;
            statWr_q   <= '0;
            statFull_q <= '0;
        end else begin
            if (accept && bus.rw && (statRd_q != 16'hFFFF)) begin
                statRd_q <= statRd_q + 16'd1;
            end
            if (accept && !bus.rw && (statWr_q != 16'hFFFF)) begin
                statWr_q <= statWr_q + 16'd1;
            end
            if (full_q && (statFull_q != 16'hFFFF)) begin
                statFull_q <= statFull_q + 16'd1;
            end
        end
    end
`endif

endmodule
